// File: rtl/seg_pkg.sv
// seg_pkg: shared segment-code table, legal scan select codes and select decoding.
package seg_pkg;
    typedef struct packed {
        logic       legal;
        logic [1:0] slot;
    } sel_dec_t;

    localparam logic [3:0] SEL_BLANK = 4'b1111;
    localparam logic [3:0] SEL_CODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [7:0] SEG_CODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic sel_dec_t decode_sel(input logic [3:0] s);
        decode_sel = '{legal: 1'b0, slot: 2'd0};
        for (int i = 0; i < 4; i++)
            if (s == SEL_CODE[i]) decode_sel = '{legal: 1'b1, slot: 2'(i)};
    endfunction
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: active-low 7-segment pattern to hex nibble; err flags patterns outside the table.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       err_o
);
    always_comb begin
        nib_o = 4'h0;
        err_o = 1'b1;
        for (int i = 0; i < 16; i++)
            if (seg_i == SEG_CODE[i][6:0]) begin
                nib_o = 4'(i);
                err_o = 1'b0;
            end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit 7-segment scan once sel has settled,
// assembles complete frames and hands them off through a valid/ready output.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel,
    input  logic [7:0]  data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_value,
    output logic        out_err,
    output logic        overrun
);
    localparam logic [3:0] SET_MAX = 4'(SETTLE);
    localparam logic [3:0] SET_HIT = 4'(SETTLE - 1);

    logic [3:0]  sel_q, cnt_q, cnt_d, mask_q, mask_d, derr_q, derr_d;
    logic [15:0] dval_q, dval_d, val_q, val_d;
    logic        vld_q, vld_d, err_q, err_d, ovr_q, ovr_d;
    logic [3:0]  nib;
    logic        nerr, stable, hit, complete, load, unused_dp;
    sel_dec_t    sd;

    seg7_to_hex u_dec (.seg_i(data[6:0]), .nib_o(nib), .err_o(nerr));

    assign unused_dp = data[7];
    assign sd        = decode_sel(sel);
    assign stable    = sel == sel_q;
    // Sample on the edge where the counter steps from SETTLE-1 to SETTLE: once per dwell.
    assign hit       = stable && sd.legal && cnt_q == SET_HIT;
    assign cnt_d     = !stable ? 4'd0 : (cnt_q == SET_MAX ? cnt_q : cnt_q + 4'd1);
    assign complete  = mask_q == 4'hF;
    assign load      = complete && (!vld_q || out_ready);

    always_comb begin
        dval_d = dval_q;
        derr_d = complete ? 4'h0 : derr_q;
        mask_d = complete ? 4'h0 : mask_q;
        if (hit) begin
            dval_d[{sd.slot, 2'b00} +: 4] = nib;
            derr_d[sd.slot]               = nerr;
            mask_d[sd.slot]               = 1'b1;
        end
        vld_d = load || (vld_q && !out_ready);
        val_d = load ? dval_q : val_q;
        err_d = load ? |derr_q : err_q;
        ovr_d = ovr_q || (complete && vld_q && !out_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q  <= SEL_BLANK;
            cnt_q  <= 4'd0;
            mask_q <= 4'h0;
            derr_q <= 4'h0;
            dval_q <= 16'h0000;
            vld_q  <= 1'b0;
            val_q  <= 16'h0000;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sel_q  <= sel;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            derr_q <= derr_d;
            dval_q <= dval_d;
            vld_q  <= vld_d;
            val_q  <= val_d;
            err_q  <= err_d;
            ovr_q  <= ovr_d;
        end
    end

    assign out_valid = vld_q;
    assign out_value = val_q;
    assign out_err   = err_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scenario tasks drive scans; a monitor pops expected frames
// from a scoreboard queue on every accepted handshake.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [7:0]  data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_value;
    logic        out_err;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;
    logic [16:0] exp_q [$];

    localparam logic [3:0] SELS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg_scan_decoder #(.SETTLE(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .data(data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_err(out_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            frames++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: got value=%h err=%b, required no frame", out_value, out_err);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({out_err, out_value} !== e) begin
                    n_fail++;
                    $display("FAIL frame_data: got value=%h err=%b, required value=%h err=%b",
                             out_value, out_err, e[15:0], e[16]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_digit(input int idx, input logic [7:0] d, input int dwell);
        sel  = SELS[idx];
        data = d;
        step(dwell);
    endtask

    task automatic scan(input logic [7:0] d0, d1, d2, d3, input int dwell);
        drive_digit(0, d0, dwell);
        drive_digit(1, d1, dwell);
        drive_digit(2, d2, dwell);
        drive_digit(3, d3, dwell);
        sel = 4'b1111;
        step(2);
    endtask

    task automatic test_reset;
        rst = 1'b0; sel = 4'b0111; data = 8'hC0; out_ready = 1'b0;
        step(3);
        n_checks++;
        if ({out_valid, out_value, out_err, overrun} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b value=%h err=%b ovr=%b, required all zero",
                     out_valid, out_value, out_err, overrun);
        end
        rst = 1'b1;
        sel = 4'b1111;
        step(2);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_valid: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_basic;
        int f0;
        f0 = frames;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 16'h3210});
        drive_digit(0, 8'hC0, 6);
        drive_digit(1, 8'hF9, 6);
        drive_digit(2, 8'hA4, 6);
        drive_digit(3, 8'hB0, 5);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b, required 0", out_valid);
        end
        step(1);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b, required 1", out_valid);
        end
        sel = 4'b1111;
        step(4);
        n_checks++;
        if (frames - f0 !== 1) begin
            n_fail++;
            $display("FAIL basic_pulse_count: got %0d, required 1", frames - f0);
        end
    endtask

    task automatic test_short_dwell;
        int f0;
        f0 = frames;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 3);
        step(4);
        n_checks++;
        if (frames - f0 !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_dwell: got frames=%0d valid=%b, required 0 and 0", frames - f0, out_valid);
        end
    endtask

    task automatic test_err;
        exp_q.push_back({1'b1, 16'hC0EF});
        scan(8'h8E, 8'h86, 8'hFF, 8'hC6, 6);
        step(2);
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h1234});
        scan(SEG[4], SEG[3], SEG[2], SEG[1], 6);
        scan(SEG[8], SEG[7], SEG[6], SEG[5], 6);
        step(2);
        n_checks++;
        if ({out_valid, out_value, out_err, overrun} !== {1'b1, 16'h1234, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid=%b value=%h err=%b ovr=%b, required 1 1234 0 1",
                     out_valid, out_value, out_err, overrun);
        end
        out_ready = 1'b1;
        step(1);
        n_checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_release: got valid=%b ovr=%b, required 0 1", out_valid, overrun);
        end
    endtask

    task automatic test_blank_glitch;
        exp_q.push_back({1'b0, 16'h3210});
        drive_digit(0, 8'hC0, 6);
        sel = 4'b1111; step(6);
        sel = 4'b1100; data = 8'h88; step(6);
        drive_digit(1, 8'hF9, 6);
        sel = 4'b0000; step(6);
        drive_digit(2, 8'hA4, 6);
        sel = 4'b1111; step(6);
        drive_digit(3, 8'hB0, 6);
        sel = 4'b1111;
        step(3);
    endtask

    task automatic test_reset_mid;
        int f0;
        out_ready = 1'b1;
        drive_digit(0, SEG[7], 6);
        drive_digit(1, SEG[7], 6);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_value, out_err, overrun} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got valid=%b value=%h err=%b ovr=%b, required all zero",
                     out_valid, out_value, out_err, overrun);
        end
        step(2);
        rst = 1'b1;
        f0 = frames;
        drive_digit(2, SEG[10], 6);
        drive_digit(3, SEG[11], 6);
        sel = 4'b1111;
        step(4);
        n_checks++;
        if (frames - f0 !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_partial: got frames=%0d valid=%b, required 0 and 0", frames - f0, out_valid);
        end
        exp_q.push_back({1'b0, 16'hBA9D});
        drive_digit(0, SEG[13], 6);
        drive_digit(1, SEG[9], 6);
        sel = 4'b1111;
        step(4);
        n_checks++;
        if (frames - f0 !== 1) begin
            n_fail++;
            $display("FAIL mid_reset_frame: got frames=%0d, required 1", frames - f0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_short_dwell;
        test_err;
        test_overrun;
        test_blank_glitch;
        test_reset_mid;
        step(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending frames, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4, consecutive stable cycles of sel required before a digit is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sel  input  4  scanned digit select, active-low one-hot; 4'b1110 is digit 0 and 4'b0111 is digit 3.
REQ-005 data  input  8  segment bus, active-low, {dp,g,f,e,d,c,b,a}.
REQ-006 out_valid  output  1  captured frame available.
REQ-007 out_ready  input  1  consumer accepts frame when out_valid && out_ready.
REQ-008 out_value  output  16  {digit3,digit2,digit1,digit0} hex nibbles.
REQ-009 out_err  output  1  at least one digit of the frame carried an undecodable pattern.
REQ-010 overrun  output  1  sticky; a complete frame was discarded because the previous frame was still pending.

Function
REQ-011 Block registers sel each cycle; stability counter resets to 0 on any sel change, otherwise increments, saturating at SETTLE.
REQ-012 Digit sample occurs exactly once per sel dwell, on the edge at which the counter reaches SETTLE; no re-sampling while sel holds.
REQ-013 sel values other than the four legal one-hot-low codes (4'b1111 blank, multi-hot, 4'b0000) are never sampled and do not clear the capture state.
REQ-014 Decode uses data[6:0] only (dp ignored), codes 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (8-bit, dp=1).
REQ-015 Undecodable pattern stores nibble 4'h0 in that slot and sets that slot's error bit.
REQ-016 Sampling a digit writes its slot and sets its bit in a 4-bit capture mask; re-sampling a slot overwrites nibble and error bit.
REQ-017 Frame completes when mask == 4'b1111; on the following edge mask and per-slot error bits clear.
REQ-018 On completion, if out_valid is 0 or out_valid && out_ready in the same cycle, out_value/out_err load and out_valid is 1 the next cycle.
REQ-019 On completion with out_valid 1 and out_ready 0, frame is discarded, overrun sets, held output unchanged.
REQ-020 out_valid clears the cycle after out_valid && out_ready unless a new frame loads in that same cycle (REQ-018).
REQ-021 out_value/out_err stay stable while out_valid is 1 and not accepted.
REQ-022 Latency: last digit sample edge to out_valid high = 1 cycle.
REQ-023 overrun clears only on reset.

Reset
REQ-024 While rst low: out_valid 0, out_value 16'h0000, out_err 0, overrun 0, mask 0, counter 0, sel register 4'b1111.
REQ-025 Reset asserted mid-frame discards partial capture; after release a full new frame of four samples is required.

Structure
REQ-026 Shared package seg_pkg holds the 16-entry active-low segment code table, the four legal sel codes and SEL_BLANK.
REQ-027 Combinational sub-module seg7_to_hex (data[6:0] -> nibble, err) is instantiated once.
REQ-028 Stability counter is 4 bits wide.

Verification
REQ-029 Scan sel 1110,1101,1011,0111 with data C0,F9,A4,B0, dwell 6 cycles each, out_ready 1 -> one out_valid pulse, out_value 16'h3210, out_err 0.
REQ-030 Same scan, dwell 3 cycles with SETTLE 4 -> no sample, out_valid stays 0.
REQ-031 Digit 2 data 8'hFF, others 8E,86,C6 -> out_value 16'hC0EF... (digit2=0), out_err 1.
REQ-032 Two complete frames (16'h1234 then 16'h5678) with out_ready 0 -> out_value holds 16'h1234, overrun 1; ready 1 -> out_valid clears next cycle.
REQ-033 Blank sel 1111 inserted between digits plus glitched multi-hot 1100 -> frame still 16'h3210, no error.
REQ-034 rst pulsed low after two digits sampled -> all outputs reset values; subsequent full scan yields correct value.
